// File: rtl/pb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : pb_uart_tx
//  Description : Push-button to UART transmitter. Each new press on pb[19:0]
//                is encoded as one ASCII byte ('0'-'9', 'A'-'F', 'W'-'Z'),
//                queued in a small FIFO and handed to the board UART through
//                a txdata / txclk / txready handshake.
//
//  Ports
//    hz100     in   1  system clock, all state changes on its rising edge
//    reset     in   1  asynchronous, active-low reset
//    pb        in  20  raw push buttons, asynchronous to hz100
//    txready   in   1  UART can accept a byte
//    txdata    out  8  byte presented to the UART (holds until next load)
//    txclk     out  1  one-cycle load strobe to the UART
//    busy      out  1  FIFO non-empty or transmitter not idle
//    overflow  out  1  sticky, a byte was discarded because the FIFO was full
//    count     out  8  bytes transmitted, modulo 256
//
//  Revision    : 1.0  initial release
// ============================================================================
module pb_uart_tx #(
    parameter int FIFO_DEPTH = 4        // power of two, minimum 2
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [19:0] pb,
    input  logic        txready,
    output logic [7:0]  txdata,
    output logic        txclk,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  count
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronizer and rising-edge detection
    // ------------------------------------------------------------------------
    logic [19:0] r_s1;
    logic [19:0] r_s2;
    logic [19:0] r_p;
    logic [19:0] w_rise;

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_p  <= '0;
        end else begin
            r_s1 <= pb;
            r_s2 <= r_s1;
            r_p  <= r_s2;
        end
    end

    // Clearing p in reset means a button held through reset release shows up
    // as a fresh rise once it has crossed the synchronizer.
    assign w_rise = r_s2 & ~r_p;

    // ------------------------------------------------------------------------
    // Encoder: lowest rising index wins, the rest are silently ignored
    // ------------------------------------------------------------------------
    function automatic logic [7:0] enc_char(input logic [4:0] idx);
        logic [7:0] v_idx;
        v_idx = {3'b000, idx};
        if (idx < 5'd10) begin
            enc_char = 8'h30 + v_idx;
        end else if (idx < 5'd16) begin
            enc_char = 8'h41 + (v_idx - 8'd10);
        end else begin
            enc_char = 8'h57 + (v_idx - 8'd16);
        end
    endfunction

    logic       w_enc_valid;
    logic [7:0] w_enc_byte;

    always_comb begin
        w_enc_valid = |w_rise;
        w_enc_byte  = 8'h00;
        // Scan downward so the last (lowest) set index overwrites the rest.
        for (int i = 19; i >= 0; i--) begin
            if (w_rise[i]) begin
                w_enc_byte = enc_char(5'(i));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Byte FIFO: pointers carry one extra wrap bit to tell full from empty
    // ------------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic [7:0]         w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);

    // A simultaneous pop frees the slot the push needs, so a full FIFO still
    // accepts the new byte in that cycle.
    assign w_push  = w_enc_valid && (!w_full || w_pop);
    assign w_drop  = w_enc_valid && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge hz100) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= w_enc_byte;
        end
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The pop only ever happens from IDLE with data present, so the FIFO can
    // never be read while empty.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && txready) begin
                    w_state_nxt = ST_LOAD;
                    w_pop       = 1'b1;
                end
            end
            ST_LOAD:   w_state_nxt = ST_STROBE;
            ST_STROBE: w_state_nxt = ST_GAP;
            // GAP gives the UART a cycle to drop txready before IDLE looks
            // at it again.
            ST_GAP:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    logic [7:0] r_txdata;
    logic       r_txclk;
    logic       r_overflow;
    logic [7:0] r_count;

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_txdata   <= 8'h00;
            r_txclk    <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= 8'h00;
        end else begin
            if (w_pop) begin
                r_txdata <= w_head;
                r_count  <= r_count + 8'd1;
            end
            // txclk is high exactly while the FSM sits in STROBE, one cycle
            // after txdata was loaded.
            r_txclk <= (w_state_nxt == ST_STROBE);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign txdata   = r_txdata;
    assign txclk    = r_txclk;
    assign overflow = r_overflow;
    assign count    = r_count;
    assign busy     = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_pb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb_uart_tx
//  Description : Self-checking bench for pb_uart_tx. A monitor records every
//                txclk strobe (byte and cycle); scenario tasks compare these
//                against bytes predicted from the button-to-ASCII rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pb_uart_tx;

    logic        hz100;
    logic        reset;
    logic [19:0] pb;
    logic        txready;
    logic [7:0]  txdata;
    logic        txclk;
    logic        busy;
    logic        overflow;
    logic [7:0]  count;

    int vectors;
    int miscompares;

    pb_uart_tx #(.FIFO_DEPTH(4)) dut (
        .hz100    (hz100),
        .reset    (reset),
        .pb       (pb),
        .txready  (txready),
        .txdata   (txdata),
        .txclk    (txclk),
        .busy     (busy),
        .overflow (overflow),
        .count    (count)
    );

    initial hz100 = 1'b0;
    always #5 hz100 = ~hz100;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    int         cyc;
    logic [7:0] got[$];
    int         stamp[$];
    int         n_long;
    int         n_unstable;
    int         run;
    logic       prev_clk;
    logic [7:0] prev_data;

    initial begin
        cyc = 0; n_long = 0; n_unstable = 0; run = 0;
        prev_clk = 1'b0; prev_data = 8'h00;
    end

    always @(posedge hz100) cyc <= cyc + 1;

    always @(negedge hz100) begin
        if (txclk === 1'b1 && prev_clk !== 1'b1) begin
            got.push_back(txdata);
            stamp.push_back(cyc);
            if (txdata !== prev_data) n_unstable++;
        end
        if (txclk === 1'b1) run++;
        else run = 0;
        if (run == 2) n_long++;
        prev_clk  = txclk;
        prev_data = txdata;
    end

    // ------------------------------------------------------------------------
    // Reference model: button index -> ASCII, lowest simultaneous press wins
    // ------------------------------------------------------------------------
    function automatic logic [7:0] model_char(input int idx);
        if (idx < 10)      return 8'(48 + idx);        // '0'..'9'
        else if (idx < 16) return 8'(65 + idx - 10);   // 'A'..'F'
        else               return 8'(87 + idx - 16);   // 'W'..'Z'
    endfunction

    function automatic int lowest(input logic [19:0] m);
        for (int i = 0; i < 20; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge hz100);
        #1;
    endtask

    task automatic press(input logic [19:0] m, input int hi, input int lo);
        pb = m;
        repeat (hi) tick();
        pb = '0;
        repeat (lo) tick();
    endtask

    task automatic do_reset();
        pb = '0;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        pb = '0; txready = 1'b1; reset = 1'b0;
        #3;
        vectors++; if (txdata !== 8'h00) begin miscompares++; $display("FAIL reset_txdata got=%h exp=00", txdata); end
        vectors++; if (txclk !== 1'b0) begin miscompares++; $display("FAIL reset_txclk got=%b exp=0", txclk); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        vectors++; if (count !== 8'h00) begin miscompares++; $display("FAIL reset_count got=%h exp=00", count); end
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_press();
        int base;
        do_reset();
        txready = 1'b1;
        base = got.size();
        pb = 20'h1 << 3;        // rises before edge k
        tick();                 // after k
        tick();                 // after k+1
        pb = '0;
        tick();                 // after k+2
        vectors++; if (txdata !== 8'h00) begin miscompares++; $display("FAIL single_early_txdata got=%h exp=00", txdata); end
        tick();                 // after k+3: LOAD
        vectors++; if (txdata !== 8'h33) begin miscompares++; $display("FAIL single_txdata got=%h exp=33", txdata); end
        vectors++; if (txclk !== 1'b0) begin miscompares++; $display("FAIL single_txclk_k3 got=%b exp=0", txclk); end
        vectors++; if (count !== 8'd1) begin miscompares++; $display("FAIL single_count got=%0d exp=1", count); end
        tick();                 // after k+4: STROBE
        vectors++; if (txclk !== 1'b1) begin miscompares++; $display("FAIL single_txclk_k4 got=%b exp=1", txclk); end
        tick();                 // after k+5: GAP
        vectors++; if (txclk !== 1'b0) begin miscompares++; $display("FAIL single_txclk_k5 got=%b exp=0", txclk); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_k5 got=%b exp=1", busy); end
        tick();                 // after k+6: IDLE
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_k6 got=%b exp=0", busy); end
        repeat (6) tick();
        vectors++; if (got.size() - base !== 1) begin miscompares++; $display("FAIL single_strobes got=%0d exp=1", got.size() - base); end
    endtask

    task automatic test_simultaneous();
        int base;
        do_reset();
        txready = 1'b1;
        base = got.size();
        press((20'h1 << 12) | (20'h1 << 17), 3, 12);
        vectors++; if (got.size() - base !== 1) begin miscompares++; $display("FAIL simul_strobes got=%0d exp=1", got.size() - base); end
        if (got.size() > base) begin
            vectors++; if (got[base] !== 8'h43) begin miscompares++; $display("FAIL simul_byte got=%h exp=43", got[base]); end
        end
        vectors++; if (count !== 8'd1) begin miscompares++; $display("FAIL simul_count got=%0d exp=1", count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL simul_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_overflow_order();
        int         base;
        int         idx[5];
        logic [7:0] exp_b[$];
        idx = '{0, 10, 16, 19, 5};
        do_reset();
        txready = 1'b0;
        base = got.size();
        for (int i = 0; i < 5; i++) begin
            press(20'h1 << idx[i], 3, 3);
            if (i < 4) exp_b.push_back(model_char(idx[i]));
        end
        repeat (4) tick();
        vectors++; if (got.size() - base !== 0) begin miscompares++; $display("FAIL ovf_held_strobes got=%0d exp=0", got.size() - base); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ovf_busy got=%b exp=1", busy); end
        vectors++; if (count !== 8'd0) begin miscompares++; $display("FAIL ovf_count_held got=%0d exp=0", count); end
        txready = 1'b1;
        repeat (24) tick();
        vectors++; if (got.size() - base !== 4) begin miscompares++; $display("FAIL ovf_drain_strobes got=%0d exp=4", got.size() - base); end
        for (int i = 0; i < 4; i++) begin
            if (got.size() > base + i) begin
                vectors++; if (got[base+i] !== exp_b[i]) begin miscompares++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, got[base+i], exp_b[i]); end
                if (i > 0) begin
                    vectors++; if (stamp[base+i] - stamp[base+i-1] !== 4) begin miscompares++; $display("FAIL ovf_spacing%0d got=%0d exp=4", i, stamp[base+i] - stamp[base+i-1]); end
                end
            end
        end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        vectors++; if (count !== 8'd4) begin miscompares++; $display("FAIL ovf_count got=%0d exp=4", count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ovf_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_hold();
        int base;
        do_reset();
        txready = 1'b1;
        base = got.size();
        press(20'h1 << 9, 50, 10);
        vectors++; if (got.size() - base !== 1) begin miscompares++; $display("FAIL hold_strobes got=%0d exp=1", got.size() - base); end
        if (got.size() > base) begin
            vectors++; if (got[base] !== 8'h39) begin miscompares++; $display("FAIL hold_byte got=%h exp=39", got[base]); end
        end
    endtask

    // 256 random presses back to back, one press every 4 cycles, which is
    // exactly the transmit rate, so nothing should be lost and count wraps.
    task automatic test_count_wrap();
        int          base;
        int          hi;
        int          bad;
        int          long0;
        int          unst0;
        logic [19:0] m;
        logic [7:0]  exp_b[$];
        do_reset();
        txready = 1'b1;
        base  = got.size();
        long0 = n_long;
        unst0 = n_unstable;
        vectors++; if (count !== 8'd0) begin miscompares++; $display("FAIL wrap_count_start got=%0d exp=0", count); end
        for (int n = 0; n < 256; n++) begin
            if ($urandom_range(0, 1) == 0) m = 20'h1 << $urandom_range(0, 19);
            else m = 20'($urandom);
            if (m == '0) m = 20'h80000;
            exp_b.push_back(model_char(lowest(m)));
            hi = $urandom_range(1, 2);
            press(m, hi, 4 - hi);
            if ($urandom_range(0, 7) == 0) tick();
        end
        repeat (30) tick();
        vectors++; if (got.size() - base !== 256) begin miscompares++; $display("FAIL wrap_strobes got=%0d exp=256", got.size() - base); end
        bad = 0;
        for (int i = 0; i < 256 && base + i < got.size(); i++) begin
            vectors++;
            if (got[base+i] !== exp_b[i]) begin
                miscompares++;
                if (bad < 8) $display("FAIL wrap_byte%0d got=%h exp=%h", i, got[base+i], exp_b[i]);
                bad++;
            end
        end
        vectors++; if (count !== 8'd0) begin miscompares++; $display("FAIL wrap_count got=%0d exp=0", count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL wrap_overflow got=%b exp=0", overflow); end
        vectors++; if (n_long - long0 !== 0) begin miscompares++; $display("FAIL wrap_long_strobes got=%0d exp=0", n_long - long0); end
        vectors++; if (n_unstable - unst0 !== 0) begin miscompares++; $display("FAIL wrap_txdata_unstable got=%0d exp=0", n_unstable - unst0); end
    endtask

    task automatic test_reset_mid_strobe();
        int   base;
        logic seen;
        do_reset();
        txready = 1'b0;
        press(20'h1 << 1, 2, 3);
        press(20'h1 << 2, 2, 3);
        txready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (txclk === 1'b1) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL midrst_strobe_seen got=%b exp=1", seen); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (txclk !== 1'b0) begin miscompares++; $display("FAIL midrst_txclk got=%b exp=0", txclk); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        vectors++; if (count !== 8'd0) begin miscompares++; $display("FAIL midrst_count got=%0d exp=0", count); end
        vectors++; if (txdata !== 8'h00) begin miscompares++; $display("FAIL midrst_txdata got=%h exp=00", txdata); end
        base = got.size();
        repeat (2) tick();
        reset = 1'b1;
        repeat (20) tick();
        vectors++; if (got.size() - base !== 0) begin miscompares++; $display("FAIL midrst_extra_strobes got=%0d exp=0", got.size() - base); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy_after got=%b exp=0", busy); end
        // A fresh press after the reset still goes through.
        press(20'h1 << 15, 2, 10);
        vectors++; if (got.size() - base !== 1) begin miscompares++; $display("FAIL midrst_new_strobes got=%0d exp=1", got.size() - base); end
        if (got.size() > base) begin
            vectors++; if (got[base] !== 8'h46) begin miscompares++; $display("FAIL midrst_new_byte got=%h exp=46", got[base]); end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pb          = '0;
        txready     = 1'b1;
        reset       = 1'b0;
        test_reset();
        test_single_press();
        test_simultaneous();
        test_overflow_order();
        test_hold();
        test_count_wrap();
        test_reset_mid_strobe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
